// File: rtl/counter_array_param.sv
// counter_array_param
// Bank of NUM_CNT independent CNT_W-bit up/down counters driven by single-cycle
// strobes (incr, decr, load, clr_all). Overflow behaviour is wrap or saturate,
// selected by SAT_MODE. Per-counter zero/max flags are decoded combinationally
// from the counter registers.
// Optional feature macro: COUNTER_ARRAY_STICKY_EN adds flag_clr and the
// per-counter sticky overflow/underflow bits ovf_sticky / unf_sticky.
module counter_array_param #(
    parameter int NUM_CNT  = 8,
    parameter int CNT_W    = 5,
    parameter int ADDR_W   = $clog2(NUM_CNT),
    parameter int SAT_MODE = 0,
    parameter int INIT_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 incr,
    input  logic [ADDR_W-1:0]    incr_addr,
    input  logic                 decr,
    input  logic [ADDR_W-1:0]    decr_addr,
    input  logic                 load,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [CNT_W-1:0]     load_val,
    input  logic                 clr_all,
`ifdef COUNTER_ARRAY_STICKY_EN
    input  logic                 flag_clr,
    output logic [NUM_CNT-1:0]   ovf_sticky,
    output logic [NUM_CNT-1:0]   unf_sticky,
`endif
    output logic [CNT_W-1:0]     cnt [0:NUM_CNT-1],
    output logic [NUM_CNT-1:0]   zero_flag,
    output logic [NUM_CNT-1:0]   max_flag
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_VAL);
    localparam bit               SAT      = (SAT_MODE != 0);

    // One-hot per-counter strobe decode. An address >= NUM_CNT matches no
    // counter, so out-of-range strobes fall away here with no extra logic.
    logic [NUM_CNT-1:0] hit_inc;
    logic [NUM_CNT-1:0] hit_dec;
    logic [NUM_CNT-1:0] hit_ld;

    logic [CNT_W-1:0]   cnt_nxt [0:NUM_CNT-1];

    // Decode each strobe's address into a per-counter hit vector.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // value before any branch; a path that skips an assignment would
        // infer a latch.
        hit_inc = '0;
        hit_dec = '0;
        hit_ld  = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            hit_inc[i] = incr && (incr_addr == ADDR_W'(i));
            hit_dec[i] = decr && (decr_addr == ADDR_W'(i));
            hit_ld[i]  = load && (load_addr == ADDR_W'(i));
        end
    end

    // Next value per counter, priority clr_all > load > incr/decr.
    // incr and decr on the same counter cancel and leave it untouched.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_nxt[i] = cnt[i];
            if (clr_all) begin
                cnt_nxt[i] = CNT_INIT;
            end else if (hit_ld[i]) begin
                cnt_nxt[i] = load_val;
            end else if (hit_inc[i] && !hit_dec[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    cnt_nxt[i] = SAT ? CNT_MAX : '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end else if (hit_dec[i] && !hit_inc[i]) begin
                if (cnt[i] == '0) begin
                    cnt_nxt[i] = SAT ? '0 : CNT_MAX;
                end else begin
                    cnt_nxt[i] = cnt[i] - 1'b1;
                end
            end
        end
    end

    // Counter registers; cnt is driven straight from these flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every counter
        // samples the pre-edge values. The bank is flops, not RAM, so it is
        // reset to INIT_VAL like any other register.
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= CNT_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Status flags decoded from the registered counter values.
    always_comb begin
        zero_flag = '0;
        max_flag  = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            zero_flag[i] = (cnt[i] == '0);
            max_flag[i]  = (cnt[i] == CNT_MAX);
        end
    end

`ifdef COUNTER_ARRAY_STICKY_EN
    logic [NUM_CNT-1:0] ovf_evt;
    logic [NUM_CNT-1:0] unf_evt;

    // Overflow/underflow events: only increments/decrements that actually
    // apply (not masked by clr_all, load or a cancelling opposite strobe).
    always_comb begin
        ovf_evt = '0;
        unf_evt = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (!clr_all && !hit_ld[i]) begin
                ovf_evt[i] = hit_inc[i] && !hit_dec[i] && (cnt[i] == CNT_MAX);
                unf_evt[i] = hit_dec[i] && !hit_inc[i] && (cnt[i] == '0);
            end
        end
    end

    // Sticky bits: cleared by rst or flag_clr; a same-cycle event wins over
    // flag_clr. clr_all deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= '0;
            unf_sticky <= '0;
        end else begin
            ovf_sticky <= (flag_clr ? '0 : ovf_sticky) | ovf_evt;
            unf_sticky <= (flag_clr ? '0 : unf_sticky) | unf_evt;
        end
    end
`endif

endmodule

// File: tb/tb_counter_array_param.sv
// tb_counter_array_param
// Three instances: A (8x5, wrap), B (8x5, saturate) share stimulus;
// C (6x8, wrap, INIT_VAL=5) exercises non-power-of-two banks and out-of-range
// addresses. An integer reference model applies the counter rules directly.
// Sticky checks are compiled in when COUNTER_ARRAY_STICKY_EN is defined.
module tb_counter_array_param;

    typedef struct {
        bit rst;
        bit clr;
        bit ld;
        int ld_addr;
        int ld_val;
        bit inc;
        int inc_addr;
        bit dec;
        int dec_addr;
        bit fclr;
    } op_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Shared inputs for A/B, separate inputs for C.
    logic       ab_rst, ab_incr, ab_decr, ab_load, ab_clr, ab_fclr;
    logic [2:0] ab_incr_addr, ab_decr_addr, ab_load_addr;
    logic [4:0] ab_load_val;
    logic       c_rst, c_incr, c_decr, c_load, c_clr, c_fclr;
    logic [2:0] c_incr_addr, c_decr_addr, c_load_addr;
    logic [7:0] c_load_val;

    logic [4:0] a_cnt [0:7];
    logic [4:0] b_cnt [0:7];
    logic [7:0] c_cnt [0:5];
    logic [7:0] a_zero, a_max, b_zero, b_max;
    logic [5:0] c_zero, c_max;
    logic [7:0] a_ovf, a_unf, b_ovf, b_unf;
    logic [5:0] c_ovf, c_unf;

    counter_array_param #(.NUM_CNT(8), .CNT_W(5), .SAT_MODE(0), .INIT_VAL(0)) u_a (
        .clk(clk), .rst(ab_rst),
        .incr(ab_incr), .incr_addr(ab_incr_addr),
        .decr(ab_decr), .decr_addr(ab_decr_addr),
        .load(ab_load), .load_addr(ab_load_addr), .load_val(ab_load_val),
        .clr_all(ab_clr),
`ifdef COUNTER_ARRAY_STICKY_EN
        .flag_clr(ab_fclr), .ovf_sticky(a_ovf), .unf_sticky(a_unf),
`endif
        .cnt(a_cnt), .zero_flag(a_zero), .max_flag(a_max)
    );

    counter_array_param #(.NUM_CNT(8), .CNT_W(5), .SAT_MODE(1), .INIT_VAL(0)) u_b (
        .clk(clk), .rst(ab_rst),
        .incr(ab_incr), .incr_addr(ab_incr_addr),
        .decr(ab_decr), .decr_addr(ab_decr_addr),
        .load(ab_load), .load_addr(ab_load_addr), .load_val(ab_load_val),
        .clr_all(ab_clr),
`ifdef COUNTER_ARRAY_STICKY_EN
        .flag_clr(ab_fclr), .ovf_sticky(b_ovf), .unf_sticky(b_unf),
`endif
        .cnt(b_cnt), .zero_flag(b_zero), .max_flag(b_max)
    );

    counter_array_param #(.NUM_CNT(6), .CNT_W(8), .SAT_MODE(0), .INIT_VAL(5)) u_c (
        .clk(clk), .rst(c_rst),
        .incr(c_incr), .incr_addr(c_incr_addr),
        .decr(c_decr), .decr_addr(c_decr_addr),
        .load(c_load), .load_addr(c_load_addr), .load_val(c_load_val),
        .clr_all(c_clr),
`ifdef COUNTER_ARRAY_STICKY_EN
        .flag_clr(c_fclr), .ovf_sticky(c_ovf), .unf_sticky(c_unf),
`endif
        .cnt(c_cnt), .zero_flag(c_zero), .max_flag(c_max)
    );

`ifndef COUNTER_ARRAY_STICKY_EN
    assign a_ovf = '0; assign a_unf = '0;
    assign b_ovf = '0; assign b_unf = '0;
    assign c_ovf = '0; assign c_unf = '0;
`endif

    // ---------------- reference model ----------------
    int ncnt [3] = '{8, 8, 6};
    int maxv [3] = '{31, 31, 255};
    bit sat  [3] = '{1'b0, 1'b1, 1'b0};
    int initv[3] = '{0, 0, 5};
    int m    [3][8];
    bit ovf  [3][8];
    bit unf  [3][8];

    function automatic op_t mk(bit inc = 0, int ia = 0, bit dec = 0, int da = 0,
                               bit ld = 0, int la = 0, int lv = 0,
                               bit clr = 0, bit rst = 0, bit fclr = 0);
        op_t o;
        o.inc = inc; o.inc_addr = ia; o.dec = dec; o.dec_addr = da;
        o.ld = ld; o.ld_addr = la; o.ld_val = lv;
        o.clr = clr; o.rst = rst; o.fclr = fclr;
        return o;
    endfunction

    task automatic model_step(input int d, input op_t o);
        if (o.rst) begin
            for (int i = 0; i < 8; i++) begin
                m[d][i] = initv[d]; ovf[d][i] = 0; unf[d][i] = 0;
            end
            return;
        end
        if (o.fclr) begin
            for (int i = 0; i < 8; i++) begin
                ovf[d][i] = 0; unf[d][i] = 0;
            end
        end
        if (o.clr) begin
            for (int i = 0; i < ncnt[d]; i++) m[d][i] = initv[d];
            return;
        end
        for (int i = 0; i < ncnt[d]; i++) begin
            bit l, up, dn;
            l  = o.ld  && (o.ld_addr  == i);
            up = o.inc && (o.inc_addr == i);
            dn = o.dec && (o.dec_addr == i);
            if (l) begin
                m[d][i] = o.ld_val % (maxv[d] + 1);
            end else if (up && !dn) begin
                if (m[d][i] == maxv[d]) begin
                    ovf[d][i] = 1;
                    m[d][i] = sat[d] ? maxv[d] : 0;
                end else begin
                    m[d][i] = m[d][i] + 1;
                end
            end else if (dn && !up) begin
                if (m[d][i] == 0) begin
                    unf[d][i] = 1;
                    m[d][i] = sat[d] ? 0 : maxv[d];
                end else begin
                    m[d][i] = m[d][i] - 1;
                end
            end
        end
    endtask

    // Packed view {unf, ovf, max, zero, cnt[7..0] as bytes}; sticky lanes
    // stay zero in the default build.
    function automatic logic [95:0] exp_state(input int d);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < ncnt[d]; i++) begin
            r[8*i +: 8] = 8'(m[d][i]);
            r[64 + i]   = (m[d][i] == 0);
            r[72 + i]   = (m[d][i] == maxv[d]);
`ifdef COUNTER_ARRAY_STICKY_EN
            r[80 + i]   = ovf[d][i];
            r[88 + i]   = unf[d][i];
`endif
        end
        return r;
    endfunction

    function automatic logic [95:0] get_obs(input int d);
        logic [95:0] r;
        r = '0;
        case (d)
            0: begin
                for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(a_cnt[i]);
                r[64 +: 8] = a_zero; r[72 +: 8] = a_max;
                r[80 +: 8] = a_ovf;  r[88 +: 8] = a_unf;
            end
            1: begin
                for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(b_cnt[i]);
                r[64 +: 8] = b_zero; r[72 +: 8] = b_max;
                r[80 +: 8] = b_ovf;  r[88 +: 8] = b_unf;
            end
            default: begin
                for (int i = 0; i < 6; i++) r[8*i +: 8] = c_cnt[i];
                r[64 +: 8] = 8'(c_zero); r[72 +: 8] = 8'(c_max);
                r[80 +: 8] = 8'(c_ovf);  r[88 +: 8] = 8'(c_unf);
            end
        endcase
        return r;
    endfunction

    // One clock: drive at negedge, advance the model at posedge, settle 1ns.
    task automatic cycle(input op_t oab, input op_t oc);
        @(negedge clk);
        ab_rst = oab.rst; ab_clr = oab.clr; ab_fclr = oab.fclr;
        ab_incr = oab.inc; ab_incr_addr = 3'(oab.inc_addr);
        ab_decr = oab.dec; ab_decr_addr = 3'(oab.dec_addr);
        ab_load = oab.ld;  ab_load_addr = 3'(oab.ld_addr); ab_load_val = 5'(oab.ld_val);
        c_rst = oc.rst; c_clr = oc.clr; c_fclr = oc.fclr;
        c_incr = oc.inc; c_incr_addr = 3'(oc.inc_addr);
        c_decr = oc.dec; c_decr_addr = 3'(oc.dec_addr);
        c_load = oc.ld;  c_load_addr = 3'(oc.ld_addr); c_load_val = 8'(oc.ld_val);
        @(posedge clk);
        model_step(0, oab);
        model_step(1, oab);
        model_step(2, oc);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle(mk(.rst(1)), mk(.rst(1)));
        cycle(mk(), mk());
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== exp_state(d)) begin
                errors++;
                $display("FAIL reset dut%0d: got %h expected %h", d, get_obs(d), exp_state(d));
            end
        end
        checks++;
        if (a_zero !== 8'hFF || a_max !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: zero=%h max=%h expected ff/00", a_zero, a_max);
        end
        checks++;
        if (c_cnt[0] !== 8'd5 || c_zero !== 6'h00) begin
            errors++;
            $display("FAIL reset_init_val: cnt0=%0d zero=%h expected 5/00", c_cnt[0], c_zero);
        end
    endtask

    task automatic test_wrap_saturate();
        cycle(mk(.rst(1)), mk(.rst(1)));
        for (int k = 1; k <= 33; k++) begin
            cycle(mk(1, 3), mk(1, 3));
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (get_obs(d) !== exp_state(d)) begin
                    errors++;
                    $display("FAIL wrap_sat step%0d dut%0d: got %h expected %h",
                             k, d, get_obs(d), exp_state(d));
                end
            end
            if (k == 31) begin
                checks++;
                if (a_cnt[3] !== 5'd31 || a_max[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL at_max: cnt=%0d max=%b expected 31/1", a_cnt[3], a_max[3]);
                end
            end
        end
        checks++;
        if (a_cnt[3] !== 5'd1 || b_cnt[3] !== 5'd31) begin
            errors++;
            $display("FAIL wrap_end: wrap=%0d sat=%0d expected 1/31", a_cnt[3], b_cnt[3]);
        end
    endtask

    task automatic test_same_addr();
        cycle(mk(.rst(1)), mk(.rst(1)));
        cycle(mk(.ld(1), .la(2), .lv(10)), mk(.ld(1), .la(2), .lv(10)));
        cycle(mk(1, 2, 1, 2), mk(1, 2, 1, 2));
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== exp_state(d)) begin
                errors++;
                $display("FAIL same_addr dut%0d: got %h expected %h", d, get_obs(d), exp_state(d));
            end
        end
        cycle(mk(1, 2, 1, 5), mk(1, 2, 1, 5));
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== exp_state(d)) begin
                errors++;
                $display("FAIL diff_addr dut%0d: got %h expected %h", d, get_obs(d), exp_state(d));
            end
        end
        checks++;
        if (a_cnt[2] !== 5'd11 || a_cnt[5] !== 5'd31 || b_cnt[5] !== 5'd0) begin
            errors++;
            $display("FAIL diff_addr_vals: c2=%0d a5=%0d b5=%0d expected 11/31/0",
                     a_cnt[2], a_cnt[5], b_cnt[5]);
        end
    endtask

    task automatic test_load_priority();
        cycle(mk(.rst(1)), mk(.rst(1)));
        cycle(mk(.ld(1), .la(1), .lv(6)), mk(.ld(1), .la(1), .lv(6)));
        cycle(mk(1, 4, 1, 1, 1, 4, 17), mk(1, 4, 1, 1, 1, 4, 17));
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== exp_state(d)) begin
                errors++;
                $display("FAIL load_prio dut%0d: got %h expected %h", d, get_obs(d), exp_state(d));
            end
        end
        checks++;
        if (a_cnt[4] !== 5'd17 || a_cnt[1] !== 5'd5) begin
            errors++;
            $display("FAIL load_prio_vals: c4=%0d c1=%0d expected 17/5", a_cnt[4], a_cnt[1]);
        end
        cycle(mk(1, 0, 1, 2, 1, 3, 9, 1), mk(1, 0, 1, 2, 1, 3, 9, 1));
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== exp_state(d)) begin
                errors++;
                $display("FAIL clr_prio dut%0d: got %h expected %h", d, get_obs(d), exp_state(d));
            end
        end
        checks++;
        if (a_zero !== 8'hFF || c_cnt[3] !== 8'd5) begin
            errors++;
            $display("FAIL clr_prio_vals: zero=%h c3=%0d expected ff/5", a_zero, c_cnt[3]);
        end
    endtask

    task automatic test_bad_addr();
        cycle(mk(.rst(1)), mk(.rst(1)));
        cycle(mk(), mk(1, 7));
        cycle(mk(), mk(1, 6, 1, 7));
        cycle(mk(), mk(.ld(1), .la(6), .lv(99)));
        cycle(mk(), mk(.dec(1), .da(7), .ld(1), .la(7), .lv(1)));
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== exp_state(d)) begin
                errors++;
                $display("FAIL bad_addr dut%0d: got %h expected %h", d, get_obs(d), exp_state(d));
            end
        end
        checks++;
        if (c_cnt[5] !== 8'd5 || c_cnt[0] !== 8'd5) begin
            errors++;
            $display("FAIL bad_addr_vals: c5=%0d c0=%0d expected 5/5", c_cnt[5], c_cnt[0]);
        end
    endtask

    task automatic test_rst_burst();
        cycle(mk(.rst(1)), mk(.rst(1)));
        for (int k = 0; k < 8; k++) begin
            op_t o;
            o = mk(1, 0);
            o.rst = (k == 4);
            cycle(o, o);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (get_obs(d) !== exp_state(d)) begin
                    errors++;
                    $display("FAIL rst_burst step%0d dut%0d: got %h expected %h",
                             k, d, get_obs(d), exp_state(d));
                end
            end
        end
        checks++;
        if (a_cnt[0] !== 5'd3 || c_cnt[0] !== 8'd8) begin
            errors++;
            $display("FAIL rst_burst_end: a0=%0d c0=%0d expected 3/8", a_cnt[0], c_cnt[0]);
        end
    endtask

    task automatic test_random();
        cycle(mk(.rst(1)), mk(.rst(1)));
        for (int k = 0; k < 400; k++) begin
            op_t oab, oc;
            oab = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 255)),
                     $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                     $urandom_range(0, 7) == 0);
            oc  = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 255)),
                     $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                     $urandom_range(0, 7) == 0);
            cycle(oab, oc);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (get_obs(d) !== exp_state(d)) begin
                    errors++;
                    $display("FAIL random step%0d dut%0d: got %h expected %h",
                             k, d, get_obs(d), exp_state(d));
                end
            end
        end
    endtask

`ifdef COUNTER_ARRAY_STICKY_EN
    task automatic test_sticky();
        cycle(mk(.rst(1)), mk(.rst(1)));
        cycle(mk(.dec(1), .da(0)), mk(.dec(1), .da(0)));
        checks++;
        if (a_unf[0] !== 1'b1 || b_unf[0] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: a=%b b=%b expected 1/1", a_unf[0], b_unf[0]);
        end
        cycle(mk(.clr(1)), mk(.clr(1)));
        checks++;
        if (a_unf[0] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_clr_all: got %b expected 1", a_unf[0]);
        end
        cycle(mk(.dec(1), .da(0), .fclr(1)), mk(.dec(1), .da(0), .fclr(1)));
        checks++;
        if (a_unf[0] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins: got %b expected 1", a_unf[0]);
        end
        cycle(mk(.fclr(1)), mk(.fclr(1)));
        checks++;
        if (a_unf[0] !== 1'b0 || b_unf[0] !== 1'b0) begin
            errors++;
            $display("FAIL sticky_flag_clr: a=%b b=%b expected 0/0", a_unf[0], b_unf[0]);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_obs(d) !== exp_state(d)) begin
                errors++;
                $display("FAIL sticky dut%0d: got %h expected %h", d, get_obs(d), exp_state(d));
            end
        end
    endtask
`endif

    initial begin
        ab_rst = 1'b1; ab_clr = 1'b0; ab_fclr = 1'b0;
        ab_incr = 1'b0; ab_decr = 1'b0; ab_load = 1'b0;
        ab_incr_addr = '0; ab_decr_addr = '0; ab_load_addr = '0; ab_load_val = '0;
        c_rst = 1'b1; c_clr = 1'b0; c_fclr = 1'b0;
        c_incr = 1'b0; c_decr = 1'b0; c_load = 1'b0;
        c_incr_addr = '0; c_decr_addr = '0; c_load_addr = '0; c_load_val = '0;

        test_reset();
        test_wrap_saturate();
        test_same_addr();
        test_load_priority();
        test_bad_addr();
        test_rst_burst();
`ifdef COUNTER_ARRAY_STICKY_EN
        test_sticky();
`endif
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
